// File: rtl/wave_nco_core_if.sv
// Sample-engine bus: ROM read ports (A: wave/ECG, B: noise sine) and sample output toward the DAC stage.
// The master side is the core; the slave side is the ROM plus the downstream sink.
interface wave_nco_core_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 10
);
  logic        [ADDR_W:0]   rom_a_addr;
  logic        [DATA_W-1:0] rom_a_data;
  logic        [ADDR_W-1:0] rom_b_addr;
  logic        [DATA_W-1:0] rom_b_data;
  logic signed [DATA_W-1:0] sample;
  logic                     valid;

  modport master (
    output rom_a_addr, rom_b_addr, sample, valid,
    input  rom_a_data, rom_b_data
  );

  modport slave (
    input  rom_a_addr, rom_b_addr, sample, valid,
    output rom_a_data, rom_b_data
  );
endinterface

// File: rtl/wave_nco_core.sv
// Sample-rate waveform engine: phase accumulators, ROM/synthesised waves, gain and saturation.
// Optional noise mixing is enabled by defining WAVE_NOISE_MIX_EN.
module wave_nco_core #(
  parameter int unsigned       DATA_W     = 24,
  parameter int unsigned       ADDR_W     = 10,
  parameter int unsigned       GAIN_W     = 4,
  parameter int unsigned       GAIN_SHIFT = 2,
  parameter logic [DATA_W-1:0] LFSR_SEED  = DATA_W'(24'h000001)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sample_en,
  input  logic [2:0]               i_sel_wave,
  input  logic [2:0]               i_sel_duty_cycle,
  input  logic [ADDR_W-1:0]        i_phase_step_wave,
  input  logic [ADDR_W-1:0]        i_phase_step_noise,
  input  logic signed [GAIN_W-1:0] i_gain_wave,
  input  logic signed [GAIN_W-1:0] i_gain_noise,
  input  logic                     i_add_noise,
  input  logic                     i_lfsr_sin,
  wave_nco_core_if.master          bus
);
  localparam int unsigned PROD_W = DATA_W + GAIN_W;
  localparam int unsigned EXT_W  = PROD_W + 1;
  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic [2:0]               sel;
    logic [2:0]               duty;
    logic signed [GAIN_W-1:0] gain_w;
    logic signed [GAIN_W-1:0] gain_n;
    logic                     add_noise;
    logic                     lfsr_sin;
  } cfg_t;

  function automatic logic signed [DATA_W-1:0] sat_w(input logic signed [EXT_W-1:0] x);
    if (x > EXT_W'(S_MAX)) return S_MAX;
    if (x < EXT_W'(S_MIN)) return S_MIN;
    return DATA_W'(x);
  endfunction

  function automatic logic signed [DATA_W-1:0] scale(input logic signed [DATA_W-1:0] raw,
                                                     input logic signed [GAIN_W-1:0] g);
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(raw) * PROD_W'(g);
    return sat_w(EXT_W'(prod >>> GAIN_SHIFT));
  endfunction

  // Square thresholds are tabulated for a 1024-entry phase and rescaled to ADDR_W.
  function automatic logic [ADDR_W-1:0] duty_thr(input logic [2:0] d);
    int unsigned t;
    case (d)
      3'd0:    t = 102;
      3'd1:    t = 205;
      3'd2:    t = 256;
      3'd3:    t = 338;
      3'd4:    t = 512;
      3'd5:    t = 768;
      3'd6:    t = 819;
      default: t = 922;
    endcase
    return ADDR_W'((t << ADDR_W) >> 10);
  endfunction

  logic [ADDR_W-1:0]        acc_w, acc_n;
  logic [DATA_W-1:0]        lfsr, lfsr_next_c;
  cfg_t                     cfg_in_c;
  logic                     s1_valid, s2_valid, s3_valid;
  cfg_t                     s1_cfg, s2_cfg, s3_cfg;
  logic [ADDR_W-1:0]        s1_p_w, s1_p_n;
  logic [DATA_W-1:0]        s1_lfsr, s2_lfsr, s3_lfsr;
  logic [DATA_W-1:0]        synth_c, s2_synth, s3_synth;
  logic [ADDR_W-2:0]        fold_c;
  logic signed [DATA_W-1:0] raw_c, wave_c, mix_c;
  logic                     unused_ok;

  assign lfsr_next_c = {lfsr[DATA_W-2:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};

  always_comb begin
    cfg_in_c           = '0;
    cfg_in_c.sel       = i_sel_wave;
    cfg_in_c.duty      = i_sel_duty_cycle;
    cfg_in_c.gain_w    = i_gain_wave;
    cfg_in_c.gain_n    = i_gain_noise;
    cfg_in_c.add_noise = i_add_noise;
    cfg_in_c.lfsr_sin  = i_lfsr_sin;
  end

  // Synthesised shapes from the captured wave phase; triangle folds the upper half back down.
  always_comb begin
    synth_c = '0;
    fold_c  = s1_p_w[ADDR_W-2:0] ^ {(ADDR_W-1){s1_p_w[ADDR_W-1]}};
    case (s1_cfg.sel)
      3'b001: synth_c = (s1_p_w < duty_thr(s1_cfg.duty)) ? S_MAX : S_MIN;
      3'b010: synth_c = {~fold_c[ADDR_W-2], fold_c[ADDR_W-3:0], {(DATA_W-ADDR_W+1){1'b0}}};
      3'b011: synth_c = {~s1_p_w[ADDR_W-1], s1_p_w[ADDR_W-2:0], {(DATA_W-ADDR_W){1'b0}}};
      default: synth_c = '0;
    endcase
  end

  // Output stage: ROM data is valid this cycle; select, scale and optionally mix.
  always_comb begin
    raw_c = '0;
    case (s3_cfg.sel)
      3'b000, 3'b100:         raw_c = bus.rom_a_data;
      3'b001, 3'b010, 3'b011: raw_c = s3_synth;
      3'b110:                 raw_c = s3_lfsr;
      3'b111:                 raw_c = bus.rom_b_data;
      default:                raw_c = '0;
    endcase
    wave_c = scale(raw_c, s3_cfg.gain_w);
`ifdef WAVE_NOISE_MIX_EN
    mix_c = s3_cfg.add_noise
          ? sat_w(EXT_W'(wave_c) + EXT_W'(scale(s3_cfg.lfsr_sin ? bus.rom_b_data : s3_lfsr,
                                                 s3_cfg.gain_n)))
          : wave_c;
`else
    mix_c = wave_c;
`endif
  end

`ifdef WAVE_NOISE_MIX_EN
  assign unused_ok = ^{s3_cfg.duty};
`else
  assign unused_ok = ^{s3_cfg.duty, s3_cfg.gain_n, s3_cfg.add_noise, s3_cfg.lfsr_sin};
`endif

  // Three-stage pipeline; each stage loads only when its predecessor holds a live sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_w          <= '0;
      acc_n          <= '0;
      lfsr           <= LFSR_SEED;
      s1_valid       <= 1'b0;
      s2_valid       <= 1'b0;
      s3_valid       <= 1'b0;
      s1_cfg         <= '0;
      s2_cfg         <= '0;
      s3_cfg         <= '0;
      s1_p_w         <= '0;
      s1_p_n         <= '0;
      s1_lfsr        <= '0;
      s2_lfsr        <= '0;
      s3_lfsr        <= '0;
      s2_synth       <= '0;
      s3_synth       <= '0;
      bus.rom_a_addr <= '0;
      bus.rom_b_addr <= '0;
      bus.sample     <= '0;
      bus.valid      <= 1'b0;
    end else begin
      s1_valid <= i_sample_en;
      if (i_sample_en) begin
        acc_w   <= acc_w + i_phase_step_wave;
        acc_n   <= acc_n + i_phase_step_noise;
        lfsr    <= lfsr_next_c;
        s1_cfg  <= cfg_in_c;
        s1_p_w  <= acc_w;
        s1_p_n  <= acc_n;
        s1_lfsr <= lfsr;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        bus.rom_a_addr <= {s1_cfg.sel == 3'b100, s1_p_w};
        bus.rom_b_addr <= s1_p_n;
        s2_cfg         <= s1_cfg;
        s2_lfsr        <= s1_lfsr;
        s2_synth       <= synth_c;
      end
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_cfg   <= s2_cfg;
        s3_lfsr  <= s2_lfsr;
        s3_synth <= s2_synth;
      end
      bus.valid <= s3_valid;
      if (s3_valid) bus.sample <= mix_c;
    end
  end
endmodule

// File: tb/tb_wave_nco_core.sv
// Directed bench for wave_nco_core: hand-computed vectors plus a sample-level reference model.
// Builds with or without WAVE_NOISE_MIX_EN; expectations follow the macro.
module tb_wave_nco_core;
  logic              clk;
  logic              rst, en;
  logic [2:0]        sel, duty;
  logic [9:0]        step_w, step_n;
  logic signed [3:0] gain_w, gain_n;
  logic              add_noise, lfsr_sin;

  wave_nco_core_if bus ();

  wave_nco_core dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_sample_en        (en),
    .i_sel_wave         (sel),
    .i_sel_duty_cycle   (duty),
    .i_phase_step_wave  (step_w),
    .i_phase_step_noise (step_n),
    .i_gain_wave        (gain_w),
    .i_gain_noise       (gain_n),
    .i_add_noise        (add_noise),
    .i_lfsr_sin         (lfsr_sin),
    .bus                (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: port A returns its address except a full-scale negative word at phase 1000.
  function automatic logic [23:0] rom_a_fn(input logic [10:0] a);
    if (a[9:0] == 10'd1000) return 24'h800000;
    return 24'(a);
  endfunction
  function automatic logic [23:0] rom_b_fn(input logic [9:0] a);
    return 24'({a, 4'b0000});
  endfunction

  always_ff @(posedge clk) begin
    bus.rom_a_data <= rom_a_fn(bus.rom_a_addr);
    bus.rom_b_data <= rom_b_fn(bus.rom_b_addr);
  end

  int          passed, total, cyc, hi_cnt;
  int          ph_w, ph_n;
  logic [23:0] lfsr_m;
  longint      exp_q[$];
  int          tick_q[$];
  string       tag;
  int          thr[8] = '{102, 205, 256, 338, 512, 768, 819, 922};
  int          wrap_ph[5] = '{0, 300, 600, 900, 176};
  logic [2:0]  sparse_sel[8] = '{3'd3, 3'd1, 3'd2, 3'd0, 3'd4, 3'd6, 3'd7, 3'd5};

  task automatic chk(input string name, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
  endtask

  function automatic longint sat24(input longint x);
    if (x > 64'sd8388607) return 64'sd8388607;
    if (x < -64'sd8388608) return -64'sd8388608;
    return x;
  endfunction

  function automatic longint scale_m(input longint raw, input int g);
    return sat24((raw * g) >>> 2);
  endfunction

  function automatic longint exp_m();
    longint r, w;
    int f;
    case (sel)
      3'd0: r = longint'($signed(rom_a_fn({1'b0, 10'(ph_w)})));
      3'd1: r = (ph_w < thr[duty]) ? 64'sd8388607 : -64'sd8388608;
      3'd2: begin
        f = (ph_w >= 512) ? 1023 - ph_w : ph_w;
        r = longint'(f) * 32768 - 8388608;
      end
      3'd3: r = longint'(ph_w) * 16384 - 8388608;
      3'd4: r = longint'($signed(rom_a_fn({1'b1, 10'(ph_w)})));
      3'd6: r = longint'($signed(lfsr_m));
      3'd7: r = longint'($signed(rom_b_fn(10'(ph_n))));
      default: r = 0;
    endcase
    w = scale_m(r, int'(gain_w));
`ifdef WAVE_NOISE_MIX_EN
    if (add_noise)
      w = sat24(w + scale_m(lfsr_sin ? longint'($signed(rom_b_fn(10'(ph_n))))
                                     : longint'($signed(lfsr_m)), int'(gain_n)));
`endif
    return w;
  endfunction

  // One clock: register a tick in the model, then check any sample that emerges.
  task automatic step(input bit tick);
    longint e;
    int t;
    en = tick;
    if (rst) begin
      exp_q.delete();
      tick_q.delete();
      ph_w   = 0;
      ph_n   = 0;
      lfsr_m = 24'h000001;
    end else if (tick) begin
      exp_q.push_back(exp_m());
      tick_q.push_back(cyc);
      ph_w   = (ph_w + int'(step_w)) % 1024;
      ph_n   = (ph_n + int'(step_n)) % 1024;
      lfsr_m = {lfsr_m[22:0], lfsr_m[23] ^ lfsr_m[22] ^ lfsr_m[21] ^ lfsr_m[16]};
    end
    @(posedge clk);
    #1;
    if (bus.valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_valid", bus.valid, 0);
      else begin
        e = exp_q.pop_front();
        t = tick_q.pop_front();
        chk("latency", cyc - t, 3);
        chk(tag, bus.sample, e);
        if (bus.sample == 24'sh7fffff) hi_cnt++;
      end
    end
    cyc++;
    en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) step(1'b0);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic tick_one();
    step(1'b1);
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    passed = 0; total = 0; cyc = 0; hi_cnt = 0;
    ph_w = 0; ph_n = 0; lfsr_m = 24'h000001;
    rst = 1'b1; en = 1'b0; sel = 3'd0; duty = 3'd0;
    step_w = 10'd0; step_n = 10'd0; gain_w = 4'sd4; gain_n = 4'sd0;
    add_noise = 1'b0; lfsr_sin = 1'b0; tag = "reset";
    step(1'b0);
    step(1'b0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_sample", bus.sample, 0);
    chk("rst_addr_a", bus.rom_a_addr, 0);
    chk("rst_addr_b", bus.rom_b_addr, 0);
    rst = 1'b0;

    // Sawtooth, tick every cycle, across a full phase wrap.
    tag = "saw"; sel = 3'd3; step_w = 10'd1; gain_w = 4'sd4;
    step(1'b1); step(1'b1); step(1'b1);
    chk("saw_no_valid_early", bus.valid, 0);
    step(1'b1);
    chk("saw_first_valid", bus.valid, 1);
    chk("saw_first", bus.sample, -8388608);
    step(1'b1);
    chk("saw_second", bus.sample, -8388608 + 16384);
    for (int i = 0; i < 1030; i++) step(1'b1);
    drain();

    // Square duty extremes: count high samples over one full period.
    tag = "square"; sel = 3'd1; duty = 3'd0; hi_cnt = 0;
    for (int i = 0; i < 1024; i++) step(1'b1);
    drain();
    chk("square_hi_duty0", hi_cnt, 102);
    duty = 3'd7; hi_cnt = 0;
    for (int i = 0; i < 1024; i++) step(1'b1);
    drain();
    chk("square_hi_duty7", hi_cnt, 922);

    // Sine ROM path, gain and saturation corners.
    do_reset();
    tag = "sine"; sel = 3'd0; gain_w = 4'sd7; step_w = 10'd1;
    step(1'b1); step(1'b1); step(1'b1); step(1'b0); step(1'b0); step(1'b0);
    chk("sine_sample2", bus.sample, 3);
    step(1'b0);
    chk("hold_valid", bus.valid, 0);
    chk("hold_sample", bus.sample, 3);
    gain_w = -4'sd8; step_w = 10'd1020; tick_one();
    chk("sine_gain_neg", bus.sample, -6);
    step_w = 10'd1001; tick_one();
    chk("sine_1023_gm8", bus.sample, -2046);
    step_w = 10'd0; tick_one();
    chk("sat_pos_clamp", bus.sample, 8388607);
    gain_w = 4'sd7; tick_one();
    chk("sat_neg_clamp", bus.sample, -8388608);
    gain_w = 4'sd0; tick_one();
    chk("gain_zero", bus.sample, 0);

    // ECG bank, noise sine on port B, LFSR and the unused select.
    tag = "ecg"; sel = 3'd4; gain_w = 4'sd4; step_w = 10'd5;
    step(1'b1); step(1'b0);
    chk("ecg_addr_bank", bus.rom_a_addr, 2024);
    drain();
    tick_one();
    chk("ecg_sample", bus.sample, 2029);
    tag = "noise_sine"; sel = 3'd7; step_n = 10'd7;
    tick_one(); tick_one();
    chk("noise_sine_sample", bus.sample, 112);
    chk("rom_b_addr", bus.rom_b_addr, 7);
    do_reset();
    tag = "lfsr"; sel = 3'd6;
    tick_one(); chk("lfsr_seed", bus.sample, 1);
    tick_one(); chk("lfsr_step1", bus.sample, 2);
    tick_one(); chk("lfsr_step2", bus.sample, 4);
    sel = 3'd5; tick_one();
    chk("sel101_zero", bus.sample, 0);

    // Step 300 wrap observed on the ROM address, then reset mid-pipeline.
    do_reset();
    tag = "wrap"; sel = 3'd0; step_w = 10'd300; step_n = 10'd0; gain_w = 4'sd4;
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      step(1'b0);
      chk("wrap_addr", bus.rom_a_addr, wrap_ph[k]);
    end
    drain();
    step(1'b1); step(1'b0);
    rst = 1'b1; step(1'b0); rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("rst_mid_valid", bus.valid, 0);
    chk("rst_mid_sample", bus.sample, 0);
    rst = 1'b1; step(1'b1); rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("rst_wins_valid", bus.valid, 0);
    chk("rst_wins_addr", bus.rom_a_addr, 0);

    // Noise mixing on a triangle (ignored when the mix feature is not built).
    do_reset();
    tag = "mix"; sel = 3'd2; step_w = 10'd1; gain_w = 4'sd4;
    add_noise = 1'b1; lfsr_sin = 1'b0; gain_n = 4'sd4;
    tick_one();
`ifdef WAVE_NOISE_MIX_EN
    chk("mix_first", bus.sample, -8388607);
`else
    chk("mix_first", bus.sample, -8388608);
`endif
    for (int i = 0; i < 10; i++) step(1'b1);
    lfsr_sin = 1'b1; step_n = 10'd3; gain_n = -4'sd3; step_w = 10'd97;
    for (int i = 0; i < 10; i++) step(1'b1);
    drain();
    add_noise = 1'b0;

    // Sparse ticks with the select changed right after each tick.
    tag = "sparse"; step_w = 10'd37; step_n = 10'd11; gain_w = 4'sd5;
    for (int i = 0; i < 8; i++) begin
      sel = sparse_sel[i];
      step(1'b1);
      sel = 3'd7 - sparse_sel[i];
      for (int j = 0; j < 4; j++) step(1'b0);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
